// File: rtl/bnn_vad_stream.sv
// Streaming binarised VAD classifier.
// MFCC window -> N_CH conv dot products (S1) -> per-channel +/-1 binarisation (S2)
// -> per-class score accumulation over N_STEPS windows -> argmax decision.
// A single stall enable freezes every stage while a decision is waiting to be taken.
module bnn_vad_stream #(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 5,
    parameter int N_CH    = 3,
    parameter int N_STEPS = 36,
    parameter int N_CLS   = 2,
    parameter int FCW_W   = 3,
    parameter int CONV_W  = 2*DATA_W + $clog2(TAPS),
    parameter int SCORE_W = FCW_W + $clog2(N_CH*N_STEPS) + 1,
    localparam int STEP_W = $clog2(N_STEPS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                mfcc_valid,
    output logic                                mfcc_ready,
    input  logic [TAPS*DATA_W-1:0]              mfcc_data,
    input  logic [N_CH*TAPS*DATA_W-1:0]         conv_wt,
    input  logic [N_CH*CONV_W-1:0]              conv_thr,
    input  logic [N_CLS*N_CH*N_STEPS*FCW_W-1:0] fc_wt,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [N_CLS-1:0]                    result,
    output logic [N_CLS*SCORE_W-1:0]            result_score,
    output logic [STEP_W-1:0]                   step_cnt
);

    logic                      en;
    logic                      acc_fire;
    logic                      frame_end;

    logic                      vld_p1_q, vld_p1_d;
    logic                      vld_p2_q, vld_p2_d;
    logic signed [CONV_W-1:0]  conv_d    [N_CH];
    logic signed [CONV_W-1:0]  conv_p1_q [N_CH];
    logic [N_CH-1:0]           b_d;
    logic [N_CH-1:0]           b_p2_q;

    logic [STEP_W-1:0]         step_cnt_q, step_cnt_d;
    logic signed [SCORE_W-1:0] score_q   [N_CLS];
    logic signed [SCORE_W-1:0] score_d   [N_CLS];
    logic signed [SCORE_W-1:0] score_sum [N_CLS];

    logic [N_CLS-1:0]          onehot;
    logic [N_CLS*SCORE_W-1:0]  score_pack;
    logic                      result_valid_q, result_valid_d;
    logic [N_CLS-1:0]          result_q, result_d;
    logic [N_CLS*SCORE_W-1:0]  result_score_q, result_score_d;

    // A decision held back by the consumer freezes the whole pipeline.
    assign en         = !(result_valid_q && !result_ready);
    assign acc_fire   = vld_p2_q && en && !clear;
    assign frame_end  = acc_fire && (step_cnt_q == STEP_W'(N_STEPS-1));

    assign mfcc_ready   = en;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign result_score = result_score_q;
    assign step_cnt     = step_cnt_q;

    // S1: full-precision signed dot product of the window with each channel's taps
    always_comb begin
        logic signed [DATA_W-1:0]   x;
        logic signed [DATA_W-1:0]   w;
        logic signed [2*DATA_W-1:0] prod;
        x    = '0;
        w    = '0;
        prod = '0;
        for (int c = 0; c < N_CH; c++) begin
            conv_d[c] = '0;
            for (int t = 0; t < TAPS; t++) begin
                x         = $signed(mfcc_data[t*DATA_W +: DATA_W]);
                w         = $signed(conv_wt[(c*TAPS+t)*DATA_W +: DATA_W]);
                prod      = x * w;
                conv_d[c] = conv_d[c] + CONV_W'(prod);
            end
        end
    end

    // S2: binarise against the channel threshold; equality maps to +1 (bit set)
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            b_d[c] = (conv_p1_q[c] >= $signed(conv_thr[c*CONV_W +: CONV_W]));
        end
    end

    // Accumulate: add +/-fc_wt for the current step, then pick the winning class
    always_comb begin
        logic signed [FCW_W-1:0]   fw;
        logic signed [SCORE_W-1:0] delta;
        logic signed [SCORE_W-1:0] best_val;
        int                        best_idx;
        fw         = '0;
        delta      = '0;
        score_pack = '0;
        for (int k = 0; k < N_CLS; k++) begin
            delta = '0;
            for (int c = 0; c < N_CH; c++) begin
                fw = $signed(fc_wt[((k*N_CH+c)*N_STEPS + int'(step_cnt_q))*FCW_W +: FCW_W]);
                if (b_p2_q[c]) delta = delta + SCORE_W'(fw);
                else           delta = delta - SCORE_W'(fw);
            end
            score_sum[k] = score_q[k] + delta;
            score_pack[k*SCORE_W +: SCORE_W] = score_sum[k];
        end
        // strict '>' keeps the lowest index on ties
        best_idx = 0;
        best_val = score_sum[0];
        for (int k = 1; k < N_CLS; k++) begin
            if (score_sum[k] > best_val) begin
                best_val = score_sum[k];
                best_idx = k;
            end
        end
        onehot           = '0;
        onehot[best_idx] = 1'b1;
    end

    // Control next state: clear beats accumulation, stall holds everything
    always_comb begin
        vld_p1_d   = vld_p1_q;
        vld_p2_d   = vld_p2_q;
        step_cnt_d = step_cnt_q;
        score_d    = score_q;
        if (clear) begin
            vld_p1_d   = 1'b0;
            vld_p2_d   = 1'b0;
            step_cnt_d = '0;
            for (int k = 0; k < N_CLS; k++) score_d[k] = '0;
        end else if (en) begin
            vld_p1_d = mfcc_valid;
            vld_p2_d = vld_p1_q;
            if (vld_p2_q) begin
                if (frame_end) begin
                    step_cnt_d = '0;
                    for (int k = 0; k < N_CLS; k++) score_d[k] = '0;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                    score_d    = score_sum;
                end
            end
        end
    end

    // Output next state: a new frame end overrides the drop after a transfer
    always_comb begin
        result_valid_d = result_valid_q && !result_ready;
        result_d       = result_q;
        result_score_d = result_score_q;
        if (frame_end) begin
            result_valid_d = 1'b1;
            result_d       = onehot;
            result_score_d = score_pack;
        end
    end

    // Pipeline valids, frame scores and step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            step_cnt_q <= '0;
            for (int k = 0; k < N_CLS; k++) score_q[k] <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            step_cnt_q <= step_cnt_d;
            score_q    <= score_d;
        end
    end

    // Stage data registers; qualified by their valids so they need no reset
    always_ff @(posedge clk) begin
        if (en && mfcc_valid) conv_p1_q <= conv_d;
        if (en && vld_p1_q)   b_p2_q    <= b_d;
    end

    // Decision register, held stable until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_q <= 1'b0;
            result_q       <= '0;
            result_score_q <= '0;
        end else begin
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            result_score_q <= result_score_d;
        end
    end

endmodule

// File: tb/tb_bnn_vad_stream.sv
// Scoreboard bench for bnn_vad_stream: a behavioural model predicts each frame's
// decision when the window that closes it is accepted; a monitor checks decisions
// as they are handed over.
module tb_bnn_vad_stream;
    localparam int DATA_W  = 16;
    localparam int TAPS    = 5;
    localparam int N_CH    = 3;
    localparam int N_STEPS = 36;
    localparam int N_CLS   = 2;
    localparam int FCW_W   = 3;
    localparam int CONV_W  = 2*DATA_W + $clog2(TAPS);
    localparam int SCORE_W = FCW_W + $clog2(N_CH*N_STEPS) + 1;
    localparam int STEP_W  = $clog2(N_STEPS);

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                clear;
    logic                                mfcc_valid;
    logic                                mfcc_ready;
    logic [TAPS*DATA_W-1:0]              mfcc_data;
    logic [N_CH*TAPS*DATA_W-1:0]         conv_wt;
    logic [N_CH*CONV_W-1:0]              conv_thr;
    logic [N_CLS*N_CH*N_STEPS*FCW_W-1:0] fc_wt;
    logic                                result_valid;
    logic                                result_ready;
    logic [N_CLS-1:0]                    result;
    logic [N_CLS*SCORE_W-1:0]            result_score;
    logic [STEP_W-1:0]                   step_cnt;

    bnn_vad_stream #(
        .DATA_W(DATA_W), .TAPS(TAPS), .N_CH(N_CH), .N_STEPS(N_STEPS),
        .N_CLS(N_CLS), .FCW_W(FCW_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .mfcc_valid(mfcc_valid), .mfcc_ready(mfcc_ready), .mfcc_data(mfcc_data),
        .conv_wt(conv_wt), .conv_thr(conv_thr), .fc_wt(fc_wt),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .result_score(result_score), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_res   = 0;
    int n_exp   = 0;

    // model configuration and state
    longint wt_m  [N_CH][TAPS];
    longint thr_m [N_CH];
    longint fc_m  [N_CLS][N_CH][N_STEPS];
    longint sc_m  [N_CLS];
    int     step_m;
    longint win   [TAPS];

    logic [N_CLS-1:0] exp_res_q [$];
    longint           exp_sc_q  [$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint dut_score(input int k);
        return longint'($signed(result_score[k*SCORE_W +: SCORE_W]));
    endfunction

    task automatic load_cfg();
        longint tmp;
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < TAPS; t++) begin
                tmp = wt_m[c][t];
                conv_wt[(c*TAPS+t)*DATA_W +: DATA_W] = tmp[DATA_W-1:0];
            end
            tmp = thr_m[c];
            conv_thr[c*CONV_W +: CONV_W] = tmp[CONV_W-1:0];
        end
        for (int k = 0; k < N_CLS; k++)
            for (int c = 0; c < N_CH; c++)
                for (int s = 0; s < N_STEPS; s++) begin
                    tmp = fc_m[k][c][s];
                    fc_wt[((k*N_CH+c)*N_STEPS+s)*FCW_W +: FCW_W] = tmp[FCW_W-1:0];
                end
    endtask

    task automatic cfg_ones(input longint fc1, input longint fc0, input longint thr);
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < TAPS; t++) wt_m[c][t] = 1;
            thr_m[c] = thr;
            for (int s = 0; s < N_STEPS; s++) begin
                fc_m[1][c][s] = fc1;
                fc_m[0][c][s] = fc0;
            end
        end
        for (int t = 0; t < TAPS; t++) win[t] = 1;
        load_cfg();
    endtask

    task automatic cfg_rand();
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < TAPS; t++) wt_m[c][t] = longint'($urandom_range(40)) - 20;
            thr_m[c] = longint'($urandom_range(400)) - 200;
            for (int k = 0; k < N_CLS; k++)
                for (int s = 0; s < N_STEPS; s++) fc_m[k][c][s] = longint'($urandom_range(7)) - 4;
        end
        load_cfg();
    endtask

    task automatic rand_win();
        for (int t = 0; t < TAPS; t++) win[t] = longint'($urandom_range(40)) - 20;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N_CLS; k++) sc_m[k] = 0;
        step_m = 0;
    endtask

    task automatic model_accept();
        longint conv;
        longint b;
        longint best;
        int     bi;
        for (int c = 0; c < N_CH; c++) begin
            conv = 0;
            for (int t = 0; t < TAPS; t++) conv += win[t] * wt_m[c][t];
            b = (conv >= thr_m[c]) ? 1 : -1;
            for (int k = 0; k < N_CLS; k++) sc_m[k] += b * fc_m[k][c][step_m];
        end
        step_m++;
        if (step_m == N_STEPS) begin
            bi = 0;
            best = sc_m[0];
            for (int k = 1; k < N_CLS; k++)
                if (sc_m[k] > best) begin best = sc_m[k]; bi = k; end
            exp_res_q.push_back(N_CLS'(1) << bi);
            for (int k = 0; k < N_CLS; k++) exp_sc_q.push_back(sc_m[k]);
            n_exp++;
            model_clear();
        end
    endtask

    // Offer the current window until accepted (bounded), then update the model
    task automatic send_window();
        longint tmp;
        bit     acc;
        int     n;
        for (int t = 0; t < TAPS; t++) begin
            tmp = win[t];
            mfcc_data[t*DATA_W +: DATA_W] = tmp[DATA_W-1:0];
        end
        mfcc_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = mfcc_ready && !clear;
            @(posedge clk);
            #1;
            n++;
        end
        mfcc_valid = 1'b0;
        chk("window_accepted", longint'(acc), 1);
        if (acc) model_accept();
    endtask

    task automatic send_frame_const(input int n);
        for (int i = 0; i < n; i++) send_window();
    endtask

    task automatic send_frame_rand(input int n);
        for (int i = 0; i < n; i++) begin
            rand_win();
            send_window();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("result_wait", longint'(result_valid), 1);
    endtask

    // Monitor: check every completed handover against the scoreboard
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            n_res++;
            if (exp_res_q.size() == 0) begin
                chk("unexpected_result", longint'(result_valid), 0);
            end else begin
                chk("result", longint'(result), longint'(exp_res_q.pop_front()));
                for (int k = 0; k < N_CLS; k++)
                    chk($sformatf("score%0d", k), dut_score(k), exp_sc_q.pop_front());
            end
        end
    end

    logic [N_CLS-1:0]         cap_res;
    logic [N_CLS*SCORE_W-1:0] cap_sc;
    logic [STEP_W-1:0]        cap_step;

    initial begin
        rst = 1'b1; clear = 1'b0; mfcc_valid = 1'b0; result_ready = 1'b1;
        mfcc_data = '0; conv_wt = '0; conv_thr = '0; fc_wt = '0;
        model_clear();
        cfg_ones(1, -1, 0);
        #12;
        chk("rst_result_valid", longint'(result_valid), 0);
        chk("rst_step_cnt", longint'(step_cnt), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_result_score", longint'(result_score), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ready_after_rst", longint'(mfcc_ready), 1);

        // 1: all-ones, class1 wins +108/-108, result two edges after last accept
        send_frame_const(N_STEPS);
        @(negedge clk); chk("lat_edge1", longint'(result_valid), 0);
        @(negedge clk); chk("lat_edge2", longint'(result_valid), 0);
        @(negedge clk); chk("lat_edge3", longint'(result_valid), 1);
        chk("s1_result", longint'(result), 2);
        chk("s1_score1", dut_score(1), 108);
        chk("s1_score0", dut_score(0), -108);
        idle(3);
        chk("s1_step_wrap", longint'(step_cnt), 0);
        chk("s1_valid_drop", longint'(result_valid), 0);
        send_frame_const(2*N_STEPS);
        idle(4);

        // 2: zero FC weights -> tie, lowest index wins
        cfg_ones(0, 0, 0);
        send_frame_const(N_STEPS);
        wait_result();
        chk("s2_result", longint'(result), 1);
        chk("s2_score1", dut_score(1), 0);
        idle(4);

        // 3: threshold boundary (conv = 5 on every channel)
        cfg_ones(1, -1, 5);
        send_frame_const(N_STEPS);
        wait_result();
        chk("s3_eq_score1", dut_score(1), 108);
        idle(4);
        cfg_ones(1, -1, 6);
        send_frame_const(N_STEPS);
        wait_result();
        chk("s3_gt_score1", dut_score(1), -108);
        chk("s3_gt_result", longint'(result), 1);
        idle(4);
        cfg_ones(1, -1, 5);
        thr_m[1] = 6;
        load_cfg();
        send_frame_const(N_STEPS);
        idle(6);

        // random weights, data and thresholds
        cfg_rand();
        send_frame_rand(2*N_STEPS);
        idle(6);

        // 4: consumer backpressure at frame end
        cfg_rand();
        result_ready = 1'b0;
        send_frame_rand(N_STEPS);
        wait_result();
        cap_res = result; cap_sc = result_score; cap_step = step_cnt;
        rand_win();
        mfcc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ready", longint'(mfcc_ready), 0);
            chk("stall_valid", longint'(result_valid), 1);
            chk("stall_result", longint'(result), longint'(cap_res));
            chk("stall_score", longint'(result_score), longint'(cap_sc));
            chk("stall_step", longint'(step_cnt), longint'(cap_step));
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        send_window();
        send_frame_rand(N_STEPS-1);
        idle(6);

        // 5: clear after 20 windows discards the partial frame
        cfg_ones(1, -1, 0);
        send_frame_const(20);
        idle(4);
        chk("s5_step20", longint'(step_cnt), 20);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        chk("s5_step_cleared", longint'(step_cnt), 0);
        send_frame_const(N_STEPS);
        wait_result();
        chk("s5_score1", dut_score(1), 108);
        idle(4);

        // 6: asynchronous reset mid-frame
        send_frame_const(17);
        idle(4);
        chk("s6_step17", longint'(step_cnt), 17);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_step", longint'(step_cnt), 0);
        chk("s6_rst_valid", longint'(result_valid), 0);
        chk("s6_rst_result", longint'(result), 0);
        chk("s6_rst_score", longint'(result_score), 0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("s6_ready", longint'(mfcc_ready), 1);
        send_frame_const(N_STEPS);
        wait_result();
        chk("s6_result", longint'(result), 2);
        idle(6);

        chk("pending_results", longint'(exp_res_q.size()), 0);
        chk("result_count", longint'(n_res), longint'(n_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_vad_stream.md
Name: bnn_vad_stream

Overview:
Parametrised streaming binarised VAD classifier for the MFCC front end. Each accepted MFCC window passes through N_CH 1-D convolution filters. Each filter output is binarised to +/-1 against a per-channel threshold. The binary values are accumulated into N_CLS class scores over N_STEPS windows, and an argmax decision is emitted per frame. Valid/ready handshakes on input and output allow the block to sit between the MFCC buffer and the VAD decision logic with backpressure.

Parameters:
DATA_W, 16, signed MFCC sample and conv weight width
TAPS, 5, conv taps (MFCC coefficients per window)
N_CH, 3, conv channels
N_STEPS, 36, windows per decision frame (>=2)
N_CLS, 2, output classes (>=2)
FCW_W, 3, signed FC weight width
CONV_W, 2*DATA_W+$clog2(TAPS), conv accumulator width (derived)
SCORE_W, FCW_W+$clog2(N_CH*N_STEPS)+1, class score width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  sync pulse: discard partial frame
mfcc_valid  in  1  window valid
mfcc_ready  out  1  block can accept window
mfcc_data  in  TAPS*DATA_W  signed taps, tap t at [t*DATA_W +: DATA_W]
conv_wt  in  N_CH*TAPS*DATA_W  signed, (c,t) at [(c*TAPS+t)*DATA_W +: DATA_W]; quasi-static
conv_thr  in  N_CH*CONV_W  signed per-channel threshold, c at [c*CONV_W +: CONV_W]; quasi-static
fc_wt  in  N_CLS*N_CH*N_STEPS*FCW_W  signed, (k,c,s) at index (k*N_CH+c)*N_STEPS+s; quasi-static
result_valid  out  1  decision available
result_ready  in  1  consumer accepts decision
result  out  N_CLS  one-hot winning class
result_score  out  N_CLS*SCORE_W  signed final scores, class k at [k*SCORE_W +: SCORE_W]
step_cnt  out  $clog2(N_STEPS)  index of next window to enter accumulation

Behaviour:
- Reset (async, rst=1): all pipeline valids=0, step_cnt=0, scores=0, result_valid=0, result=0, result_score=0. mfcc_ready=1 once rst deasserts.
- Stall: en = !(result_valid && !result_ready). mfcc_ready = en. All stages hold when en=0.
- S1 (accept, en=1, mfcc_valid=1): register conv_c = sum_t data[t]*wt[c][t] as full-precision signed CONV_W, plus v1=1. When mfcc_valid=0, set v1=0 (bubble).
- S2 (v1=1, en=1):
  - b_c = +1 if conv_c >= thr_c (signed compare; equality gives +1), else -1.
  - score_k += sum_c b_c*fc_wt[k][c][step_cnt], signed, no saturation (SCORE_W cannot overflow).
  - step_cnt increments.
- Frame end (S2 with step_cnt==N_STEPS-1):
  - Final scores include this step.
  - result = one-hot of argmax; ties go to the lowest index.
  - result_score = final scores; result_valid=1.
  - Scores clear to 0 and step_cnt wraps to 0 in the same cycle.
- Latency: last window accepted at edge t gives result_valid=1 after edge t+2 (no stall).
- Output handshake: result/result_score are held stable while result_valid && !result_ready. Transfer completes on result_valid && result_ready; result_valid drops the next cycle unless a new frame end coincides, in which case it stays 1 with the new values.
- Windows of the next frame are accepted while result_valid=1 and result_ready=1 (no bubble required).
- clear=1 (sync, priority over accumulation): scores=0, step_cnt=0, v1=0. Window accepted in the same cycle is dropped. A pending result is unaffected.
- rst mid-frame: everything returns to reset values immediately; partial frame is lost.
- Weight and threshold changes take effect on the next window entering S1/S2. Changing them mid-frame is legal but gives mixed results.

Test Plan:
1. Defaults, all data=+1, all conv_wt=+1, thr=0, fc class1=+1, class0=-1, 36 windows back-to-back -> one result_valid 2 cycles after the 36th accept, result=2'b10, scores class1=+108, class0=-108.
2. All fc_wt=0 -> scores 0/0, result=2'b01 (tie to lowest index).
3. Threshold boundary: conv_c exactly equal to thr_c=+5 -> b=+1; thr_c=+6 -> b=-1; check the sign of the class-1 score delta for that step.
4. result_ready=0 for 10 cycles at frame end -> mfcc_ready=0 and result stable for 10 cycles; step_cnt frozen; on ready=1, transfer completes and streaming resumes with no lost or duplicated windows.
5. clear after 20 windows, then 36 windows -> a single decision reflecting only the last 36 (reuse scenario 1 values: +108/-108).
6. rst asserted mid-frame at step 17 -> all outputs 0 immediately; a subsequent full frame gives a correct decision.
